// File: rtl/fib_index_search_if.sv
// Request/response bundle for the Fibonacci index search engine.
// The producer/consumer side uses master; the engine uses slave.
interface fib_index_search_if #(
    parameter int WIDTH = 64,
    parameter int IDX_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_number;
    logic                    in_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [IDX_W-1:0] out_index;
    logic [WIDTH-1:0]        out_fib;
    logic                    out_exact;
    logic                    out_ovf;

    modport master (
        output in_valid, in_number, in_mode, out_ready,
        input  in_ready, out_valid, out_index, out_fib, out_exact, out_ovf
    );

    modport slave (
        input  in_valid, in_number, in_mode, out_ready,
        output in_ready, out_valid, out_index, out_fib, out_exact, out_ovf
    );
endinterface

// File: rtl/fib_index_search.sv
// Walks the Fibonacci sequence one term per cycle to find N exactly, or the
// largest F(k) <= N, stopping early when the next term no longer fits in WIDTH.
module fib_index_search #(
    parameter int WIDTH = 64,
    parameter int IDX_W = 8
) (
    input logic              clk,
    input logic              rst,
    fib_index_search_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t                  state, next_state;
    logic [WIDTH-1:0]        num_q;
    logic                    mode_q;
    logic [WIDTH-1:0]        a_q, b_q;
    logic signed [IDX_W-1:0] k_q;
    logic signed [IDX_W-1:0] index_q;
    logic [WIDTH-1:0]        fib_q;
    logic                    exact_q, ovf_q;
    logic                    in_ready_w, out_valid_w;
    logic                    accept, hit, past, wrap;
    logic [WIDTH:0]          sum;

    assign sum    = {1'b0, a_q} + {1'b0, b_q};
    assign hit    = (b_q == num_q);
    assign past   = (b_q > num_q);
    assign wrap   = sum[WIDTH];
    assign accept = bus.in_valid && in_ready_w;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (bus.in_number == '0) ? DONE : SEARCH;
            SEARCH:  if (hit || past || wrap) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready_w  = (state == IDLE) && !rst;
        out_valid_w = (state == DONE);
    end

    // Datapath keeps a = F(k-1), b = F(k); results load only on the deciding cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q   <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            index_q <= '0;
            fib_q   <= '0;
            exact_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        num_q  <= bus.in_number;
                        mode_q <= bus.in_mode;
                        a_q    <= '0;
                        b_q    <= WIDTH'(1);
                        k_q    <= IDX_W'(1);
                        if (bus.in_number == '0) begin
                            index_q <= '0;
                            fib_q   <= '0;
                            exact_q <= 1'b1;
                            ovf_q   <= 1'b0;
                        end
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        index_q <= k_q;
                        fib_q   <= b_q;
                        exact_q <= 1'b1;
                        ovf_q   <= 1'b0;
                    end else if (past) begin
                        exact_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        index_q <= mode_q ? k_q - IDX_W'(1) : '1;
                        fib_q   <= mode_q ? a_q : '0;
                    end else if (wrap) begin
                        exact_q <= 1'b0;
                        ovf_q   <= 1'b1;
                        index_q <= mode_q ? k_q : '1;
                        fib_q   <= mode_q ? b_q : '0;
                    end else begin
                        a_q <= b_q;
                        b_q <= sum[WIDTH-1:0];
                        k_q <= k_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_index = index_q;
    assign bus.out_fib   = fib_q;
    assign bus.out_exact = exact_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_fib_index_search.sv
// Directed bench for fib_index_search: a 64-bit and an 8-bit instance share
// clock and reset; expected results are hand-computed Fibonacci indices.
module tb_fib_index_search;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fib_index_search_if #(.WIDTH(64), .IDX_W(8)) bus64 ();
    fib_index_search_if #(.WIDTH(8),  .IDX_W(8)) bus8 ();

    fib_index_search #(.WIDTH(64), .IDX_W(8)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
    fib_index_search #(.WIDTH(8),  .IDX_W(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic getOut(input bit narrow, output int idx, output logic [63:0] fib,
                          output logic valid, output logic exact, output logic ovf, output logic ready);
        if (narrow) begin
            idx = int'(bus8.out_index);  fib = 64'(bus8.out_fib);
            valid = bus8.out_valid;      exact = bus8.out_exact;
            ovf = bus8.out_ovf;          ready = bus8.in_ready;
        end else begin
            idx = int'(bus64.out_index); fib = bus64.out_fib;
            valid = bus64.out_valid;     exact = bus64.out_exact;
            ovf = bus64.out_ovf;         ready = bus64.in_ready;
        end
    endtask

    task automatic drive(input bit narrow, input logic vld, input logic [63:0] number, input logic mode);
        if (narrow) begin
            bus8.in_valid = vld; bus8.in_number = number[7:0]; bus8.in_mode = mode;
        end else begin
            bus64.in_valid = vld; bus64.in_number = number; bus64.in_mode = mode;
        end
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic acceptOnly(input bit narrow, input logic [63:0] number, input logic mode);
        int idx; logic [63:0] fib; logic v, e, o, r;
        int guard = 0;
        drive(narrow, 1'b1, number, mode);
        getOut(narrow, idx, fib, v, e, o, r);
        while (!r && guard < 50) begin
            @(negedge clk);
            guard++;
            getOut(narrow, idx, fib, v, e, o, r);
        end
        checkOutput("accept_ready", 64'(r), 64'(1));
        @(negedge clk);
        drive(narrow, 1'b0, number, mode);
    endtask

    task automatic waitResult(input bit narrow, output int lat);
        int idx; logic [63:0] fib; logic v, e, o, r;
        lat = 1;
        getOut(narrow, idx, fib, v, e, o, r);
        while (!v && lat < 300) begin
            @(negedge clk);
            lat++;
            getOut(narrow, idx, fib, v, e, o, r);
        end
        checkOutput("result_valid", 64'(v), 64'(1));
    endtask

    task automatic applyStimulus(input bit narrow, input logic [63:0] number, input logic mode, output int lat);
        acceptOnly(narrow, number, mode);
        waitResult(narrow, lat);
    endtask

    task automatic checkResult(input string tag, input bit narrow, input int exp_idx,
                               input logic [63:0] exp_fib, input logic exp_exact, input logic exp_ovf);
        int idx; logic [63:0] fib; logic v, e, o, r;
        getOut(narrow, idx, fib, v, e, o, r);
        checkOutput({tag, "_index"}, 64'(idx), 64'(exp_idx));
        checkOutput({tag, "_fib"},   fib, exp_fib);
        checkOutput({tag, "_exact"}, 64'(e), 64'(exp_exact));
        checkOutput({tag, "_ovf"},   64'(o), 64'(exp_ovf));
    endtask

    initial begin
        int idx, lat, idx0;
        logic [63:0] fib, fib0;
        logic v, e, o, r, e0, o0;
        logic seen, stable;

        clk = 1'b0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 1'b0);
        drive(1'b1, 1'b0, 64'd0, 1'b0);
        bus64.out_ready = 1'b1;
        bus8.out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        getOut(1'b0, idx, fib, v, e, o, r);
        checkOutput("rst_in_ready", 64'(r), 64'(0));
        checkOutput("rst_out_valid", 64'(v), 64'(0));
        checkResult("rst", 1'b0, 0, 64'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        getOut(1'b0, idx, fib, v, e, o, r);
        checkOutput("post_rst_ready64", 64'(r), 64'(1));
        getOut(1'b1, idx, fib, v, e, o, r);
        checkOutput("post_rst_ready8", 64'(r), 64'(1));

        // Exact N=8 -> F(6), visible 7 cycles after accept for one cycle.
        applyStimulus(1'b0, 64'd8, 1'b0, lat);
        checkResult("n8", 1'b0, 6, 64'd8, 1'b1, 1'b0);
        checkOutput("n8_latency", 64'(lat), 64'(7));
        @(negedge clk);
        getOut(1'b0, idx, fib, v, e, o, r);
        checkOutput("n8_valid_drop", 64'(v), 64'(0));

        applyStimulus(1'b0, 64'd4, 1'b0, lat);
        checkResult("n4_exact", 1'b0, -1, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'd4, 1'b1, lat);
        checkResult("n4_floor", 1'b0, 4, 64'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0, lat);
        checkResult("n0_exact", 1'b0, 0, 64'd0, 1'b1, 1'b0);
        checkOutput("n0_latency", 64'(lat), 64'(1));
        applyStimulus(1'b0, 64'd0, 1'b1, lat);
        checkResult("n0_floor", 1'b0, 0, 64'd0, 1'b1, 1'b0);
        checkOutput("n0f_latency", 64'(lat), 64'(1));
        applyStimulus(1'b0, 64'd1, 1'b0, lat);
        checkResult("n1", 1'b0, 1, 64'd1, 1'b1, 1'b0);

        // 8-bit instance: F(14)=377 no longer fits, so searches stop at k=13.
        applyStimulus(1'b1, 64'd250, 1'b1, lat);
        checkResult("w8_250_floor", 1'b1, 13, 64'd233, 1'b0, 1'b1);
        checkOutput("w8_250_latency", 64'(lat), 64'(14));
        applyStimulus(1'b1, 64'd250, 1'b0, lat);
        checkResult("w8_250_exact", 1'b1, -1, 64'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 64'd233, 1'b0, lat);
        checkResult("w8_233_exact", 1'b1, 13, 64'd233, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'd255, 1'b1, lat);
        checkResult("w8_255_floor", 1'b1, 13, 64'd233, 1'b0, 1'b1);

        // Backpressure: result must hold while the consumer stalls.
        @(negedge clk);
        bus64.out_ready = 1'b0;
        applyStimulus(1'b0, 64'd21, 1'b0, lat);
        checkResult("bp", 1'b0, 8, 64'd21, 1'b1, 1'b0);
        checkOutput("bp_latency", 64'(lat), 64'(9));
        getOut(1'b0, idx0, fib0, v, e0, o0, r);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            getOut(1'b0, idx, fib, v, e, o, r);
            if (!v || r || idx != idx0 || fib != fib0 || e != e0 || o != o0) stable = 1'b0;
        end
        checkOutput("bp_stable", 64'(stable), 64'(1));
        bus64.out_ready = 1'b1;
        @(negedge clk);
        getOut(1'b0, idx, fib, v, e, o, r);
        checkOutput("bp_valid_after", 64'(v), 64'(0));
        checkOutput("bp_ready_after", 64'(r), 64'(1));

        // Reset mid-search: pending result must be discarded.
        acceptOnly(1'b0, 64'h8000_0000_0000_0000, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            getOut(1'b0, idx, fib, v, e, o, r);
            seen = seen | v;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        getOut(1'b0, idx, fib, v, e, o, r);
        checkOutput("abort_ready", 64'(r), 64'(1));
        for (int i = 0; i < 120; i++) begin
            getOut(1'b0, idx, fib, v, e, o, r);
            seen = seen | v;
            @(negedge clk);
        end
        checkOutput("abort_no_valid", 64'(seen), 64'(0));
        applyStimulus(1'b0, 64'd13, 1'b0, lat);
        checkResult("after_abort", 1'b0, 7, 64'd13, 1'b1, 1'b0);

        // Churn inputs during SEARCH/DONE; only the accepted request matters.
        @(negedge clk);
        bus64.out_ready = 1'b0;
        acceptOnly(1'b0, 64'd21, 1'b0);
        lat = 1;
        getOut(1'b0, idx, fib, v, e, o, r);
        while (!v && lat < 300) begin
            drive(1'b0, 1'b1, {32'(0), $urandom}, 1'($urandom));
            @(negedge clk);
            lat++;
            getOut(1'b0, idx, fib, v, e, o, r);
        end
        checkOutput("churn_valid", 64'(v), 64'(1));
        checkResult("churn", 1'b0, 8, 64'd21, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 64'd5, 1'b0);
        repeat (2) @(negedge clk);
        getOut(1'b0, idx, fib, v, e, o, r);
        checkOutput("churn_done_ready", 64'(r), 64'(0));
        checkOutput("churn_done_valid", 64'(v), 64'(1));
        bus64.out_ready = 1'b1;
        @(negedge clk);
        getOut(1'b0, idx, fib, v, e, o, r);
        checkOutput("churn_idle_ready", 64'(r), 64'(1));
        @(negedge clk);
        drive(1'b0, 1'b0, 64'd5, 1'b0);
        waitResult(1'b0, lat);
        checkResult("churn_next", 1'b0, 5, 64'd5, 1'b1, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fib_index_search.md
Name: fib_index_search

Overview:
Parametrised Fibonacci index search engine that generalises the team's 64-bit Fibonacci index finder. It accepts an unsigned WIDTH-bit number over a valid/ready input handshake and walks the Fibonacci sequence one term per cycle. It has two runtime modes: exact lookup, and floor lookup (largest k with F(k) <= N). It detects sum overflow at WIDTH bits, and the result is held under output backpressure.

Parameters:
WIDTH, 64, data width of the searched number and the returned Fibonacci value (>= 8).
IDX_W, 8, signed index width; must hold the largest representable index + sign (>= 8 for WIDTH <= 64).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_number  in  WIDTH  unsigned number N to search
in_mode  in  1  0 = exact lookup, 1 = floor lookup
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_index  out  IDX_W  signed result index; -1 = not found (exact mode only)
out_fib  out  WIDTH  F(out_index); 0 when out_index = -1
out_exact  out  1  N is itself a Fibonacci number
out_ovf  out  1  search ended because F(k+1) exceeds 2^WIDTH-1

Behaviour:
- Reset: one clock, synchronous active-high, port rst; reset takes priority over every other event.
  - state -> IDLE; out_valid, out_exact, out_ovf = 0; out_index = 0; out_fib = 0.
  - in_ready = 0 while rst is high; in_ready = 1 from the first cycle after rst deasserts.
- States: IDLE, SEARCH, DONE. in_ready = (state == IDLE) && !rst. out_valid = (state == DONE). All outputs are registered, except in_ready.
- IDLE accept (in_valid && in_ready):
  - Latch N and mode. Set a = 0, b = 1, k = 1, where the invariant is a = F(k-1), b = F(k).
  - If N == 0: load index 0, fib 0, exact 1, ovf 0 in both modes, and go to DONE.
  - Otherwise go to SEARCH.
- SEARCH, per cycle, with sum = a + b computed at WIDTH+1 bits:
  - b == N: index k, fib b, exact 1 -> DONE.
  - b > N: exact 0. Floor mode: index k-1, fib a. Exact mode: index -1, fib 0. -> DONE.
  - b < N and sum[WIDTH] set: exact 0, ovf 1. Floor mode: index k, fib b. Exact mode: index -1, fib 0. -> DONE.
  - Otherwise: a <= b, b <= sum[WIDTH-1:0], k <= k+1, stay in SEARCH.
- Tie-break: N = 1 matches at k = 1, so the returned index is 1 (the lowest index).
- Latency: if accept is at edge t and the deciding compare is at k = m, out_valid is high from cycle t+m+1. For N = 0, out_valid is high from cycle t+1.
- DONE:
  - Hold out_index, out_fib, out_exact and out_ovf stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE; in_ready returns the following cycle. There is no same-cycle re-accept.
- in_number and in_mode are ignored outside the accept cycle; changes during SEARCH or DONE have no effect.
- in_valid while not ready is not an error. The request is simply held by the producer.
- rst during SEARCH or DONE aborts the operation. No result is emitted, and the pending result is discarded.
- k never exceeds IDX_W-1 positive range, because the overflow termination bounds it.

Test Plan:
1. WIDTH=64, exact mode, N=8, out_ready=1 -> index 6, fib 8, exact 1, ovf 0; out_valid first high 7 cycles after the accept edge, for exactly 1 cycle.
2. Exact mode N=4 -> index -1, fib 0, exact 0. Floor mode N=4 -> index 4, fib 3, exact 0. N=0 in both modes -> index 0, fib 0, exact 1, out_valid at t+1. N=1 -> index 1.
3. WIDTH=8: floor N=250 -> index 13, fib 233, ovf 1. Exact N=250 -> index -1, ovf 1. Exact N=233 -> index 13, exact 1, ovf 0. Floor N=255 -> index 13, ovf 1.
4. Backpressure: N=21 with out_ready=0 for 5 cycles -> out_valid and all outputs stable across the stall; in_ready stays 0 until the cycle after the out_ready handshake.
5. Reset mid-search: N=2^63 accepted, rst pulsed 10 cycles later -> out_valid never asserts, in_ready=1 after rst drops. A new request N=13 then returns index 7.
6. Input churn: change in_number and in_mode every cycle during SEARCH -> result matches the value latched at accept. in_valid held during DONE is not accepted until IDLE.
